// File: rtl/ccff_loader_pkg.sv
// Purpose : shared types and constants for the ccff configuration-chain loader.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: loader FSM state enum, CLR counter width helper, default widths.
package ccff_loader_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 20;
  localparam int DEF_CLR_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bits needed to count 0 .. cycles-1, never less than one bit.
  function automatic int clr_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/ccff_ser.sv
// Purpose : word serializer; holds one bitstream word and its count of unshifted bits.
// Latency : load takes effect on the next clk_i edge; one bit leaves per shift_i cycle.
// Backpressure: none internally; the parent only loads when empty or on the last bit.
// Ports   : clk_i/rst_n_i (sync active-low), clr_i, load_i + load_dat_i/load_cnt_i,
//           shift_i; next-state view cnt_nxt_o, empty_nxt_o, last_nxt_o, bit0_nxt_o.
module ccff_ser #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_dat_i,
  input  logic [CNT_W-1:0]  load_cnt_i,
  input  logic              shift_i,
  output logic [CNT_W-1:0]  cnt_nxt_o,
  output logic              empty_nxt_o,
  output logic              last_nxt_o,
  output logic              bit0_nxt_o
);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // A load may coincide with the shift of the final bit of the previous word;
  // the load wins because that bit has already been presented this cycle.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      sreg_d = load_dat_i;
      cnt_d  = load_cnt_i;
    end else if (shift_i && (cnt_q != '0)) begin
      sreg_d = sreg_q >> 1;
      cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state view so the parent can register its outputs without a bubble.
  assign cnt_nxt_o   = cnt_d;
  assign empty_nxt_o = (cnt_d == '0);
  assign last_nxt_o  = (cnt_d == CNT_W'(1));
  assign bit0_nxt_o  = sreg_d[0];

endmodule

// File: rtl/ccff_chain_loader.sv
// Purpose : streams host bitstream words LSB-first into a ccff_head/ccff_tail chain.
// Latency : word accepted in cycle t drives its bit 0 on ccff_head in t+1; chain_preset
//           is held CLR_CYCLES cycles first. Backpressure: cfg_ready only when the
//           serializer frees up and bits remain; an empty serializer just stalls.
// Ports   : prog_clk, pReset_N (sync active-low), start/abort/cfg_len, cfg_data/
//           cfg_valid/cfg_ready host stream, ccff_head/config_enable/chain_preset
//           chain drive, busy/done status. Every output is a flop.
// Option  : CCFF_LOADER_READBACK_EN adds ccff_tail capture and the rb_data/rb_valid/
//           rb_ready readback stream; shifting pauses while a readback word is held.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
  input  logic              prog_clk,
  input  logic              pReset_N,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              config_enable,
  output logic              chain_preset,
  output logic              busy,
  output logic              done
`ifdef CCFF_LOADER_READBACK_EN
  ,
  input  logic              ccff_tail,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready
`endif
);

  localparam int WC_W  = $clog2(DATA_W) + 1;
  localparam int CMP_W = (LEN_W > WC_W) ? LEN_W : WC_W;
  localparam int CC_W  = clr_cnt_w(CLR_CYCLES);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d, rem_after;
  logic [CC_W-1:0]   clr_cnt_q, clr_cnt_d;

  logic cfg_ready_q, cfg_ready_d;
  logic ce_q, ce_d;
  logic head_q, head_d;
  logic preset_q, preset_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic            accept;
  logic            ser_clr, ser_load;
  logic [WC_W-1:0] ser_load_cnt, ser_cnt_nxt;
  logic            ser_empty_nxt, ser_last_nxt, ser_bit0_nxt;
  logic            rb_hold_d;
  logic            finish_ok;

  // The chain shifts exactly on cycles where config_enable is high, so the
  // registered strobe is also the serializer shift and the rem decrement.
  assign accept    = cfg_valid & cfg_ready_q & ~abort;
  assign rem_after = rem_q - LEN_W'(ce_q);

  ccff_ser #(
    .DATA_W (DATA_W),
    .CNT_W  (WC_W)
  ) u_ser (
    .clk_i       (prog_clk),
    .rst_n_i     (pReset_N),
    .clr_i       (ser_clr),
    .load_i      (ser_load),
    .load_dat_i  (cfg_data),
    .load_cnt_i  (ser_load_cnt),
    .shift_i     (ce_q),
    .cnt_nxt_o   (ser_cnt_nxt),
    .empty_nxt_o (ser_empty_nxt),
    .last_nxt_o  (ser_last_nxt),
    .bit0_nxt_o  (ser_bit0_nxt)
  );

`ifdef CCFF_LOADER_READBACK_EN
  localparam int RB_W = $clog2(DATA_W);

  logic [DATA_W-1:0] rb_dat_q, rb_dat_d;
  logic [RB_W-1:0]   rb_cnt_q, rb_cnt_d;
  logic              rb_vld_q, rb_vld_d;

  // ce_q is only ever set while no readback word is held, so a capture never
  // collides with a word still waiting for rb_ready.
  always_comb begin
    rb_dat_d = rb_dat_q;
    rb_cnt_d = rb_cnt_q;
    rb_vld_d = rb_vld_q;
    if (rb_vld_q && rb_ready) begin
      rb_vld_d = 1'b0;
      rb_dat_d = '0;
      rb_cnt_d = '0;
    end
    if (ce_q) begin
      rb_dat_d[rb_cnt_q] = ccff_tail;
      rb_cnt_d           = rb_cnt_q + 1'b1;
      if ((rb_cnt_q == RB_W'(DATA_W - 1)) || (rem_after == '0)) begin
        rb_vld_d = 1'b1;
      end
    end
    if (abort || (state_q == IDLE)) begin
      rb_dat_d = '0;
      rb_cnt_d = '0;
      rb_vld_d = 1'b0;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_N) begin
      rb_dat_q <= '0;
      rb_cnt_q <= '0;
      rb_vld_q <= 1'b0;
    end else begin
      rb_dat_q <= rb_dat_d;
      rb_cnt_q <= rb_cnt_d;
      rb_vld_q <= rb_vld_d;
    end
  end

  // rb_ready for next cycle is unknown here, so any held word pauses the strobe.
  assign rb_hold_d = rb_vld_d;
  assign finish_ok = (rem_q == '0) && rb_vld_q && rb_ready;
  assign rb_data   = rb_dat_q;
  assign rb_valid  = rb_vld_q;
`else
  assign rb_hold_d = 1'b0;
  assign finish_ok = (rem_after == '0);
`endif

  // Sequencing: FSM, remaining-bit counter and serializer control.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    clr_cnt_d    = clr_cnt_q;
    ser_clr      = 1'b0;
    ser_load     = 1'b0;
    ser_load_cnt = '0;
    unique case (state_q)
      IDLE: begin
        ser_clr = 1'b1;
        if (start) begin
          rem_d     = cfg_len;
          clr_cnt_d = '0;
          state_d   = CLR;
        end
      end
      CLR: begin
        if (clr_cnt_q == CC_W'(CLR_CYCLES - 1)) begin
          state_d = (rem_q == '0) ? DONE : SHIFT;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        rem_d = rem_after;
        if (accept) begin
          ser_load = 1'b1;
          // Final word: only the bits still owed to the chain are counted.
          ser_load_cnt = (CMP_W'(rem_after) >= CMP_W'(DATA_W)) ? WC_W'(DATA_W)
                                                               : WC_W'(rem_after);
        end
        if (finish_ok) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      rem_d     = '0;
      clr_cnt_d = '0;
      ser_clr   = 1'b1;
      ser_load  = 1'b0;
    end
  end

  // Output next-state, derived from the next-state view so every output is a flop.
  // cfg_ready is offered only when the serializer is free next cycle (empty, or its
  // last bit shifts) and bits beyond those already loaded are still owed.
  always_comb begin
    ce_d        = (state_d == SHIFT) && !ser_empty_nxt && !rb_hold_d;
    head_d      = ce_d && ser_bit0_nxt;
    cfg_ready_d = (state_d == SHIFT) &&
                  (CMP_W'(rem_d) > CMP_W'(ser_cnt_nxt)) &&
                  (ser_empty_nxt || (ser_last_nxt && ce_d));
    preset_d    = (state_d == CLR);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_N) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      clr_cnt_q   <= '0;
      cfg_ready_q <= 1'b0;
      ce_q        <= 1'b0;
      head_q      <= 1'b0;
      preset_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      clr_cnt_q   <= clr_cnt_d;
      cfg_ready_q <= cfg_ready_d;
      ce_q        <= ce_d;
      head_q      <= head_d;
      preset_q    <= preset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign config_enable = ce_q;
  assign ccff_head     = head_q;
  assign chain_preset  = preset_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Purpose : directed bench for ccff_chain_loader (DATA_W=8, CLR_CYCLES=4) with a
//           stream-level model: accepted words become an expected bit queue.
// Latency/backpressure observed: bit 0 one cycle after accept; stalls and gaps.
module tb_ccff_chain_loader;

  localparam int DW = 8;
  localparam int LW = 20;
  localparam int CC = 4;

  logic          prog_clk = 1'b0;
  logic          pReset_N = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, ccff_head, config_enable, chain_preset, busy, done;
`ifdef CCFF_LOADER_READBACK_EN
  logic          ccff_tail;
  logic [DW-1:0] rb_data;
  logic          rb_valid;
  logic          rb_ready;
  logic [11:0]   chain;
  logic          load_chain = 1'b0;
`endif

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.DATA_W(DW), .LEN_W(LW), .CLR_CYCLES(CC)) dut (
    .prog_clk      (prog_clk),
    .pReset_N      (pReset_N),
    .start         (start),
    .abort         (abort),
    .cfg_len       (cfg_len),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .config_enable (config_enable),
    .chain_preset  (chain_preset),
    .busy          (busy),
    .done          (done)
`ifdef CCFF_LOADER_READBACK_EN
    ,
    .ccff_tail     (ccff_tail),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid),
    .rb_ready      (rb_ready)
`endif
  );

`ifdef CCFF_LOADER_READBACK_EN
  // 12-bit chain model: new bits enter at the top, ccff_tail is the bottom bit.
  always @(posedge prog_clk) begin
    if (load_chain) chain <= 12'hABC;
    else if (config_enable) chain <= {ccff_head, chain[11:1]};
  end
  assign ccff_tail = chain[0];

  initial begin
    rb_ready = 1'b0;
    forever begin
      @(posedge prog_clk);
      #1 rb_ready = ~rb_ready;
    end
  end

  logic [DW-1:0] rb_got[$];
  int            rb_last_cyc = 0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stream model ----------------
  bit          exp_q[$];
  int          exp_len, pushed, ce_cnt, acc_words, preset_cnt, done_cnt;
  int          last_preset_cyc, done_cyc, first_acc_cyc, first_ce_cyc;
  int          cur_gap, max_gap;
  bit          aborted;
  bit          mon_en = 1'b0;
  logic [31:0] obs_bits;
  int          n_push;

  task automatic model_reset(input int len);
    exp_q.delete();
    exp_len = len; pushed = 0; ce_cnt = 0; acc_words = 0; preset_cnt = 0;
    done_cnt = 0; last_preset_cyc = -1; done_cyc = -1; first_acc_cyc = -1;
    first_ce_cyc = -1; cur_gap = 0; max_gap = 0; aborted = 1'b0; obs_bits = '0;
  endtask

  always @(negedge prog_clk) begin
    if (mon_en) begin
      if (chain_preset) begin
        preset_cnt++;
        last_preset_cyc = cyc;
      end
      if (config_enable) begin
        if (first_ce_cyc < 0) first_ce_cyc = cyc;
        if (exp_q.size() == 0) check("ce_without_pending_bit", 32'd1, 32'd0);
        else check("ccff_head_bit", 32'(ccff_head), 32'(exp_q.pop_front()));
        if (ce_cnt < 32) obs_bits[ce_cnt] = ccff_head;
        ce_cnt++;
        if (cur_gap > max_gap) max_gap = cur_gap;
        cur_gap = 0;
        if (chain_preset) check("ce_during_preset", 32'd1, 32'd0);
      end else begin
        check("head_zero_when_idle", 32'(ccff_head), 32'd0);
        if (ce_cnt > 0 && ce_cnt < exp_len && !aborted) cur_gap++;
      end
`ifdef CCFF_LOADER_READBACK_EN
      if (rb_valid && !rb_ready) check("stall_while_rb_blocked", 32'(config_enable), 32'd0);
      if (rb_valid && rb_ready) begin
        rb_got.push_back(rb_data);
        rb_last_cyc = cyc;
      end
`endif
      if (cfg_valid && cfg_ready && !abort) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        acc_words++;
        n_push = exp_len - pushed;
        if (n_push > DW) n_push = DW;
        if (n_push <= 0) check("extra_word_accepted", 32'd1, 32'd0);
        for (int i = 0; i < n_push; i++) exp_q.push_back(cfg_data[i]);
        if (n_push > 0) pushed += n_push;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_after_abort", 32'(aborted), 32'd0);
        check("done_pulse_total", 32'(ce_cnt), 32'(exp_len));
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
      end
      if (abort) begin
        aborted = 1'b1;
        exp_q.delete();
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_start(input int len);
    @(posedge prog_clk); #1;
    model_reset(len);
    start = 1'b1;
    cfg_len = LW'(len);
    @(posedge prog_clk); #1;
    start = 1'b0;
  endtask

  // gap>0: hold cfg_valid low until cfg_ready is seen, then for gap more cycles.
  task automatic send_word(input logic [DW-1:0] d, input int gap);
    int  n;
    bit  ok;
    ok = 1'b0;
    if (gap > 0) begin
      cfg_valid = 1'b0;
      n = 0;
      do begin
        @(negedge prog_clk);
        n++;
      end while (!cfg_ready && n < 200);
      repeat (gap) @(posedge prog_clk);
      #1;
    end
    cfg_valid = 1'b1;
    cfg_data  = d;
    n = 0;
    forever begin
      @(negedge prog_clk);
      if (cfg_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
      if (n > 200) break;
    end
    check("word_accept_timeout", 32'(ok), 32'd1);
    @(posedge prog_clk); #1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge prog_clk); #1;
      n++;
    end
    check("done_pulse_seen", 32'(done_cnt), 32'd1);
    @(negedge prog_clk);
    check("busy_low_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
    check({tag, "_config_enable"}, 32'(config_enable), 32'd0);
    check({tag, "_ccff_head"}, 32'(ccff_head), 32'd0);
    check({tag, "_chain_preset"}, 32'(chain_preset), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
`ifdef CCFF_LOADER_READBACK_EN
    check({tag, "_rb_valid"}, 32'(rb_valid), 32'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset(0);
    // Reset state
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    check_all_zero("reset");
    @(posedge prog_clk); #1;
    pReset_N = 1'b1;
    mon_en   = 1'b1;

`ifndef CCFF_LOADER_READBACK_EN
    // T1: 10 bits from 0xA5, 0x03 with cfg_valid held
    do_start(10);
    send_word(8'hA5, 0);
    send_word(8'h03, 0);
    cfg_valid = 1'b0;
    wait_done(100);
    check("t1_preset_cycles", 32'(preset_cnt), 32'd4);
    check("t1_pulses", 32'(ce_cnt), 32'd10);
    check("t1_words_accepted", 32'(acc_words), 32'd2);
    check("t1_head_sequence", obs_bits & 32'h3FF, 32'h3A5);
    check("t1_gapless", 32'(max_gap), 32'd0);
    check("t1_first_bit_latency", 32'(first_ce_cyc - first_acc_cyc), 32'd1);

    // T2: 16 bits, second word offered 5 cycles late
    do_start(16);
    send_word(8'h3C, 0);
    send_word(8'hC3, 5);
    cfg_valid = 1'b0;
    wait_done(100);
    check("t2_pulses", 32'(ce_cnt), 32'd16);
    check("t2_gap_cycles", 32'(max_gap), 32'd5);
    check("t2_head_sequence", obs_bits & 32'hFFFF, 32'hC33C);

    // T3: abort after 3 shifted bits, then a fresh load
    do_start(16);
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    n = 0;
    while (ce_cnt < 3 && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    check("t3_reached_3_bits", 32'(ce_cnt >= 3), 32'd1);
    @(posedge prog_clk); #1;
    abort = 1'b1;
    @(posedge prog_clk); #1;
    abort = 1'b0;
    cfg_valid = 1'b0;
    @(negedge prog_clk);
    check("t3_ce_dropped", 32'(config_enable), 32'd0);
    check("t3_preset_low", 32'(chain_preset), 32'd0);
    check("t3_ready_dropped", 32'(cfg_ready), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);
    repeat (6) @(posedge prog_clk);
    check("t3_no_done", 32'(done_cnt), 32'd0);
    do_start(5);
    send_word(8'h16, 0);
    cfg_valid = 1'b0;
    wait_done(100);
    check("t3_reload_preset", 32'(preset_cnt), 32'd4);
    check("t3_reload_bits", obs_bits & 32'h1F, 32'h16);

    // T4: zero-length load with data offered throughout
    do_start(0);
    cfg_valid = 1'b1;
    cfg_data  = 8'h55;
    wait_done(50);
    cfg_valid = 1'b0;
    check("t4_preset_cycles", 32'(preset_cnt), 32'd4);
    check("t4_pulses", 32'(ce_cnt), 32'd0);
    check("t4_words_accepted", 32'(acc_words), 32'd0);
    check("t4_done_after_clr", 32'(done_cyc - last_preset_cyc), 32'd1);

    // T5a: start pulsed mid-SHIFT is ignored
    do_start(12);
    send_word(8'h5A, 0);
    @(posedge prog_clk); #1;
    start = 1'b1;
    cfg_len = LW'(3);
    cfg_data = 8'h0F;
    @(posedge prog_clk); #1;
    start = 1'b0;
    send_word(8'h0F, 0);
    cfg_valid = 1'b0;
    wait_done(100);
    check("t5_pulses_unchanged", 32'(ce_cnt), 32'd12);
    check("t5_head_sequence", obs_bits & 32'hFFF, 32'hF5A);
    repeat (8) @(posedge prog_clk);
    check("t5_no_restart", 32'(preset_cnt), 32'd4);
    check("t5_still_idle", 32'(busy), 32'd0);

    // T5b: reset mid-SHIFT
    do_start(12);
    send_word(8'h5A, 0);
    cfg_valid = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    pReset_N = 1'b0;
    @(posedge prog_clk); #1;
    aborted = 1'b1;
    exp_q.delete();
    @(negedge prog_clk);
    check_all_zero("midreset");
    @(posedge prog_clk); #1;
    pReset_N = 1'b1;
    repeat (6) @(posedge prog_clk);
    @(negedge prog_clk);
    check("midreset_stays_idle", 32'(busy), 32'd0);
    check("midreset_no_done", 32'(done_cnt), 32'd0);
`else
    // Readback: chain preloaded 0xABC, 12 bits loaded, rb_ready toggling
    @(posedge prog_clk); #1;
    load_chain = 1'b1;
    @(posedge prog_clk); #1;
    load_chain = 1'b0;
    do_start(12);
    send_word(8'h33, 0);
    send_word(8'h05, 0);
    cfg_valid = 1'b0;
    wait_done(300);
    check("rb_pulses", 32'(ce_cnt), 32'd12);
    check("rb_word_count", 32'(rb_got.size()), 32'd2);
    if (rb_got.size() >= 2) begin
      check("rb_word0", 32'(rb_got[0]), 32'hBC);
      check("rb_word1", 32'(rb_got[1]), 32'h0A);
    end
    check("rb_done_after_last_word", 32'(done_cyc > rb_last_cyc), 32'd1);
    check("rb_chain_contents", 32'(chain), 32'h533);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain sequencer for tiles whose memories hang off a ccff_head/ccff_tail shift chain, such as connection blocks, IO logical tiles and mux memories.
- Accepts bitstream words from a host over a valid/ready interface and drives the chain control signals: chain reset, per-bit config_enable strobe and serial ccff_head.
- Serializes each word LSB-first and stops after exactly cfg_len bits.
- Sits between the SoC configuration port and the fabric's ccff/pReset/config_enable distribution buffers.

Parameters:
- DATA_W, 32, width of host bitstream word (power of 2, >= 2).
- LEN_W, 20, width of the cfg_len bit-count input.
- CLR_CYCLES, 4, cycles chain_preset is held high before shifting (>= 1).

Ports:
- prog_clk  in  1  configuration clock; all state on rising edge.
- pReset_N  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- abort  in  1  synchronous abort, any state.
- cfg_len  in  LEN_W  total chain bits; sampled on accepted start.
- cfg_data  in  DATA_W  bitstream word, bit 0 shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted when cfg_valid && cfg_ready.
- ccff_head  out  1  serial data into chain.
- config_enable  out  1  chain shifts one bit on each prog_clk edge where high.
- chain_preset  out  1  active-high reset to chain memories (drives fabric pReset).
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (pReset_N low at a clock edge): state IDLE.
  - All outputs 0; counters and shift register cleared.
- IDLE:
  - start=1 latches cfg_len and moves to CLR.
  - busy rises the next cycle.
- CLR:
  - chain_preset=1 for exactly CLR_CYCLES cycles.
  - Then move to SHIFT, or to DONE if the latched length is 0.
- SHIFT: registered shift register sreg, word bit counter wcnt, remaining counter rem (LEN_W bits).
  - cfg_ready=1 when sreg is empty, or when the last bit of the current word is being shifted this cycle, and rem exceeds the bits in flight. This gives gapless streaming.
  - A word accepted at cycle t produces its first config_enable/ccff_head=bit0 at t+1, then one bit per cycle.
  - config_enable=1 and ccff_head=sreg[0] exactly in cycles where a bit is pending. ccff_head=0 when config_enable=0.
  - If sreg is empty and cfg_valid=0: config_enable=0 (stall), no timeout.
  - Each shifted bit decrements rem.
  - Final word: only rem bits are shifted; remaining upper bits are discarded. No further cfg_ready once all bits are covered.
  - rem reaching 0 moves to DONE.
- DONE:
  - done=1 for one cycle, then IDLE.
  - Total config_enable pulses always equals the latched cfg_len.
- abort:
  - Takes priority over every other event in the same cycle.
  - Next state IDLE; config_enable, chain_preset and cfg_ready drop the following cycle.
  - done is not asserted.
  - A word offered in the abort cycle is not accepted.
- start outside IDLE is ignored.
- cfg_len wraps nothing; the full 2^LEN_W-1 range is legal.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro CCFF_LOADER_READBACK_EN.
- With the macro:
  - Adds ports ccff_tail (in 1), rb_data (out DATA_W), rb_valid (out 1), rb_ready (in 1).
  - ccff_tail is captured on every config_enable cycle and packed LSB-first into rb_data.
  - rb_valid asserts once DATA_W bits are collected, or on the final partial word, with upper bits zero.
  - While rb_valid=1 and rb_ready=0, shifting stalls (config_enable=0). Ordering and bit count are preserved.
  - DONE is entered only after the last rb word handshakes.
  - abort discards readback.
- Without the macro: readback ports and logic are absent; behaviour is as above.

Decomposition:
- Package ccff_loader_pkg holds:
  - state enum (IDLE, CLR, SHIFT, DONE);
  - CLR counter width function;
  - default DATA_W/LEN_W constants.
- One sub-module, ccff_ser: word serializer holding sreg/wcnt with load/shift/empty/last signals.
- The FSM, rem counter and readback packer stay in the top level.

Test Plan:
- DATA_W=8, cfg_len=10, words 0xA5 then 0x03 with cfg_valid held -> chain_preset high 4 cycles, then 10 contiguous config_enable cycles with ccff_head = 1,0,1,0,0,1,0,1,1,1 -> done pulse, busy low. Only 2 words accepted.
- cfg_len=16, second word's cfg_valid delayed 5 cycles -> exactly 5-cycle config_enable gap, ccff_head=0 during gap, 16 pulses total.
- abort asserted after 3 shifted bits -> config_enable low next cycle, no done, IDLE. A fresh start then reloads from CLR.
- cfg_len=0 -> CLR only, zero config_enable pulses, done one cycle after CLR ends.
- start pulsed while busy, and pReset_N low mid-SHIFT -> start ignored. Reset forces all outputs 0 on the next edge.
- Readback build: model chain of 12 bits preloaded 0xABC, load 12 bits with rb_ready toggling -> rb words 0xBC then 0x0A (DATA_W=8). Shifting stalls while rb_valid && !rb_ready.
